// File: rtl/fetch_pkg.sv
// Shared widths, constants and the fetch queue entry type for the IF stage.
package fetch_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [PC_W-1:0]    PC_STEP   = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries: a write is visible at the head after the same edge.
// Push and pop may occur together when full. Clear empties the queue and wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         valid,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;
  fetch_entry_t  mem [DEPTH];

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & valid & ~clear;
  // A pop frees the head slot in the same edge, so a full queue can still take a write.
  assign do_push = push & (~full | do_pop) & ~clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register plus fetch queue; a fetched word reaches the head one edge later, and the queue stalls fetch when full.
// FETCH_PERF_EN adds saturating redirect and stall counters. A redirect flushes the queue regardless of stall.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        redirect_cnt_o,
  output logic [31:0]        stall_cnt_o
`endif
);
  logic [PC_W-1:0] pc_q;
  logic            push;
  logic            pop;
  logic            full;
  logic            head_valid;
  fetch_entry_t    head;
  fetch_entry_t    fetched;

  assign imem_addr_o   = pc_q;
  assign fetched.pc    = pc_q;
  assign fetched.instr = imem_data_i;
  assign pop  = head_valid & ~stall_i;
  assign push = ~redirect_i & (~full | pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          pc_q <= RESET_PC;
    else if (redirect_i) pc_q <= redirect_pc_i;
    else if (push)       pc_q <= pc_q + PC_STEP;
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (push),
    .pop   (pop),
    .clear (redirect_i),
    .din   (fetched),
    .head  (head),
    .valid (head_valid),
    .full  (full)
  );

  // Empty queue presents a NOP at PC 0 so ID never sees stale storage.
  assign valid_o = head_valid;
  assign pc_o    = head_valid ? head.pc    : '0;
  assign instr_o = head_valid ? head.instr : NOP_INSTR;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      redirect_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      if (redirect_i && redirect_cnt_o != 32'hFFFF_FFFF)
        redirect_cnt_o <= redirect_cnt_o + 32'd1;
      if (head_valid && stall_i && stall_cnt_o != 32'hFFFF_FFFF)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage; imem returns 32'h100 + address.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] addr, data, pc, instr;
  logic        valid;
  logic [31:0] addr_w, data_w, pc_w, instr_w;
  logic        valid_w;
  logic        stall_w = 1'b0;
  logic        redir_w = 1'b0;
  logic [31:0] rpc_w = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] rcnt, scnt, rcnt_w, scnt_w;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign data   = addr + 32'h100;
  assign data_w = addr_w + 32'h100;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redir),
    .redirect_pc_i(rpc), .imem_addr_o(addr), .imem_data_i(data),
    .valid_o(valid), .pc_o(pc), .instr_o(instr)
`ifdef FETCH_PERF_EN
    , .redirect_cnt_o(rcnt), .stall_cnt_o(scnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk_i(clk), .rst_i(rst), .stall_i(stall_w), .redirect_i(redir_w),
    .redirect_pc_i(rpc_w), .imem_addr_o(addr_w), .imem_data_i(data_w),
    .valid_o(valid_w), .pc_o(pc_w), .instr_o(instr_w)
`ifdef FETCH_PERF_EN
    , .redirect_cnt_o(rcnt_w), .stall_cnt_o(scnt_w)
`endif
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
  } vec_t;

  vec_t        vecs [17];
  logic [31:0] wrap_pc [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    // stall, redirect, target | valid, pc, instr, imem_addr (sampled before the edge)
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13,  32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h100, 32'h4};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h100, 32'h8};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h100, 32'h8};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h100, 32'h8};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h100, 32'h8};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h104, 32'hC};
    vecs[7]  = '{1'b0, 1'b1, 32'h40,  1'b1, 32'h8,   32'h108, 32'h10};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13,  32'h40};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h40,  32'h140, 32'h44};
    vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h40,  32'h140, 32'h48};
    vecs[11] = '{1'b1, 1'b1, 32'h83,  1'b1, 32'h40,  32'h140, 32'h48};
    vecs[12] = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h13,  32'h83};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13,  32'h200};
    vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 32'h300, 32'h204};
    vecs[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 32'h304, 32'h208};
    vecs[16] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 32'h304, 32'h20C};
    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000;
    wrap_pc[3] = 32'h0000_0004;

    #12;
    check("reset_valid", {31'b0, valid}, 32'h0);
    check("reset_pc",    pc,    32'h0);
    check("reset_instr", instr, 32'h13);
    check("reset_addr",  addr,  32'h0);
    check("reset_addr_wrapdut", addr_w, 32'hFFFF_FFF8);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      stall = vecs[i].stall;
      redir = vecs[i].redir;
      rpc   = vecs[i].rpc;
      #1;
      check($sformatf("row%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].v});
      check($sformatf("row%0d_pc", i),    pc,    vecs[i].pc);
      check($sformatf("row%0d_instr", i), instr, vecs[i].instr);
      check($sformatf("row%0d_addr", i),  addr,  vecs[i].addr);
      if (i >= 1 && i <= 4) begin
        check($sformatf("wrap%0d_pc", i),    pc_w,    wrap_pc[i-1]);
        check($sformatf("wrap%0d_instr", i), instr_w, wrap_pc[i-1] + 32'h100);
      end
      @(posedge clk);
      @(negedge clk);
    end

`ifdef FETCH_PERF_EN
    check("perf_redirect_cnt", rcnt, 32'd3);
    check("perf_stall_cnt",    scnt, 32'd9);
`endif

    // Queue is full here; reset asserted between edges must empty it at once.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, valid}, 32'h0);
    check("async_rst_pc",    pc,    32'h0);
    check("async_rst_instr", instr, 32'h13);
    check("async_rst_addr",  addr,  32'h0);
`ifdef FETCH_PERF_EN
    check("async_rst_rcnt", rcnt, 32'h0);
    check("async_rst_scnt", scnt, 32'h0);
`endif
    stall = 1'b0;
    redir = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("restart_valid0", {31'b0, valid}, 32'h0);
    @(posedge clk);
    #1;
    check("restart_valid1", {31'b0, valid}, 32'h1);
    check("restart_pc1",    pc,    32'h0);
    check("restart_instr1", instr, 32'h100);
    @(posedge clk);
    #1;
    check("restart_pc2",    pc,    32'h4);
    check("restart_instr2", instr, 32'h104);
    check("restart_addr2",  addr,  32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
